// File: rtl/exec_instr_gen_pkg.sv
// Shared types and limits for the ExecInstrGen multiplier pipe.
package exec_instr_gen_pkg;

    // Deepest pipeline the multiplier supports; occupancy is 4 bits wide.
    localparam int MUL_MAX_STAGE = 8;

    // Per-beat operand interpretation: 1 = two's complement, 0 = unsigned.
    typedef struct packed {
        logic a_sgn;
        logic b_sgn;
    } mul_mode_t;

    // Beat counter update: +1 on accept, -1 on retire, unchanged when both or neither.
    function automatic logic [3:0] occ_next(input logic [3:0] occ,
                                            input logic       inc,
                                            input logic       dec);
        logic [3:0] nxt;
        nxt = occ;
        if (inc && !dec) begin
            nxt = occ + 4'd1;
        end else if (!inc && dec) begin
            nxt = occ - 4'd1;
        end
        return nxt;
    endfunction

endpackage

// File: rtl/exec_instr_gen_mul_stage.sv
// One enable-gated pipeline register: a valid bit plus a data word.
// Data only loads when the incoming beat is valid, so bubble contents
// (possibly X) never overwrite the word held behind a valid beat.
module exec_instr_gen_mul_stage #(
    parameter int WIDTH    = 32,
    parameter bit RST_DATA = 1'b0
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             en,
    input  logic             d_valid,
    input  logic [WIDTH-1:0] d_data,
    output logic             q_valid,
    output logic [WIDTH-1:0] q_data
);

    // Valid bit shifts with every advance, carrying bubbles as well as beats.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            q_valid <= 1'b0;
        end else if (en) begin
            q_valid <= d_valid;
        end
    end

    generate
        if (RST_DATA) begin : g_data_rst
            // Output-facing data word: cleared on reset so the result port reads 0.
            always_ff @(posedge clk or posedge rst) begin
                if (rst) begin
                    q_data <= '0;
                end else if (en && d_valid) begin
                    q_data <= d_data;
                end
            end
        end else begin : g_data_norst
            // Internal data word: no reset so it can fold into DSP pipeline registers.
            always_ff @(posedge clk) begin
                if (en && d_valid) begin
                    q_data <= d_data;
                end
            end
        end
    endgenerate

endmodule

// File: rtl/exec_instr_gen_mul_pipe.sv
// Parametrised pipelined multiplier for ExecInstrGen address/stride math.
// Handshake: a beat moves on in_valid & in_ready and a result on
// out_valid & out_ready; the whole pipe advances in lockstep only when the
// output register is empty or being drained (adv), so a stalled result keeps
// out_valid/out_p stable and in_ready never looks at in_valid.
module exec_instr_gen_mul_pipe
    import exec_instr_gen_pkg::*;
#(
    parameter int A_W       = 16,
    parameter int B_W       = 16,
    parameter int P_W       = 32,
    parameter int NUM_STAGE = 3
) (
    input  logic           ap_clk,
    input  logic           ap_rst,
    input  logic           in_valid,
    output logic           in_ready,
    input  logic [A_W-1:0] in_a,
    input  logic [B_W-1:0] in_b,
    input  logic           in_a_sgn,
    input  logic           in_b_sgn,
    output logic           out_valid,
    input  logic           out_ready,
    output logic [P_W-1:0] out_p,
    output logic [3:0]     occupancy
);

    // Two sign-extended operands packed together are exactly this wide,
    // which is also the width the signed product is evaluated at.
    localparam int EXT_W = A_W + B_W + 2;

    mul_mode_t      mode;
    logic [A_W:0]   a_ext;
    logic [B_W:0]   b_ext;
    logic           adv;
    logic           in_fire;
    logic           out_fire;
    logic           last_valid;
    logic [P_W-1:0] last_p;
    logic [3:0]     occ;

    // Signed multiply of the extended operands; the low A_W+B_W bits equal
    // the product for every signed/unsigned combination.
    function automatic logic [EXT_W-1:0] mul_full(input logic [A_W:0] a,
                                                  input logic [B_W:0] b);
        logic signed [EXT_W-1:0] aw;
        logic signed [EXT_W-1:0] bw;
        aw = {{(B_W+1){a[A_W]}}, a};
        bw = {{(A_W+1){b[B_W]}}, b};
        return aw * bw;
    endfunction

    // Operand extension: the extra MSB is the sign only when that operand is signed.
    always_comb begin
        mode.a_sgn = in_a_sgn;
        mode.b_sgn = in_b_sgn;
        a_ext      = {mode.a_sgn & in_a[A_W-1], in_a};
        b_ext      = {mode.b_sgn & in_b[B_W-1], in_b};
    end

    assign adv       = ~last_valid | out_ready;
    assign in_ready  = adv;
    assign in_fire   = in_valid & adv;
    assign out_fire  = last_valid & out_ready;
    assign out_valid = last_valid;
    assign out_p     = last_p;
    assign occupancy = occ;

    generate
        if (NUM_STAGE == 1) begin : g_one
            logic [EXT_W-1:0] prod;
            logic             unused_prod_hi;

            assign prod           = mul_full(a_ext, b_ext);
            assign unused_prod_hi = ^prod[EXT_W-1:P_W];

            exec_instr_gen_mul_stage #(
                .WIDTH    (P_W),
                .RST_DATA (1'b1)
            ) u_out (
                .clk     (ap_clk),
                .rst     (ap_rst),
                .en      (adv),
                .d_valid (in_valid),
                .d_data  (prod[P_W-1:0]),
                .q_valid (last_valid),
                .q_data  (last_p)
            );
        end else begin : g_multi
            logic             s0_valid;
            logic [EXT_W-1:0] s0_ops;
            logic [EXT_W-1:0] prod;
            logic             unused_prod_hi;
            logic             pv [1:NUM_STAGE-1];
            logic [P_W-1:0]   pd [1:NUM_STAGE-1];

            // Stage 0 holds the extended operands; the multiply sits after it.
            exec_instr_gen_mul_stage #(
                .WIDTH    (EXT_W),
                .RST_DATA (1'b0)
            ) u_s0 (
                .clk     (ap_clk),
                .rst     (ap_rst),
                .en      (adv),
                .d_valid (in_valid),
                .d_data  ({a_ext, b_ext}),
                .q_valid (s0_valid),
                .q_data  (s0_ops)
            );

            assign prod           = mul_full(s0_ops[EXT_W-1:B_W+1], s0_ops[B_W:0]);
            assign unused_prod_hi = ^prod[EXT_W-1:P_W];

            // Stage 1 captures the product; later stages are retiming registers.
            for (genvar k = 1; k < NUM_STAGE; k++) begin : g_pipe
                logic           dv;
                logic [P_W-1:0] dd;

                if (k == 1) begin : g_src_mul
                    assign dv = s0_valid;
                    assign dd = prod[P_W-1:0];
                end else begin : g_src_prev
                    assign dv = pv[k-1];
                    assign dd = pd[k-1];
                end

                exec_instr_gen_mul_stage #(
                    .WIDTH    (P_W),
                    .RST_DATA (k == NUM_STAGE - 1)
                ) u_stg (
                    .clk     (ap_clk),
                    .rst     (ap_rst),
                    .en      (adv),
                    .d_valid (dv),
                    .d_data  (dd),
                    .q_valid (pv[k]),
                    .q_data  (pd[k])
                );
            end

            assign last_valid = pv[NUM_STAGE-1];
            assign last_p     = pd[NUM_STAGE-1];
        end
    endgenerate

    // Beats in flight: counts accepts minus retires, cleared by reset.
    always_ff @(posedge ap_clk or posedge ap_rst) begin
        if (ap_rst) begin
            occ <= 4'd0;
        end else begin
            occ <= occ_next(occ, in_fire, out_fire);
        end
    end

    // A stalled result must stay put until the consumer takes it.
    property p_out_hold;
        @(posedge ap_clk) disable iff (ap_rst)
            (out_valid && !out_ready) |=> (out_valid && $stable(out_p));
    endproperty
    a_out_hold: assert property (p_out_hold);

    // The counter can never exceed the number of pipeline slots.
    property p_occ_bound;
        @(posedge ap_clk) disable iff (ap_rst)
            occ <= 4'(NUM_STAGE);
    endproperty
    a_occ_bound: assert property (p_occ_bound);

endmodule

// File: tb/tb_exec_instr_gen_mul_pipe.sv
// Directed bench for exec_instr_gen_mul_pipe: a 16x16->32, 3-stage instance
// plus a 16x16->24, 1-stage instance for truncation and the single-register path.
module tb_exec_instr_gen_mul_pipe;

    localparam int A_W  = 16;
    localparam int B_W  = 16;
    localparam int P_W  = 32;
    localparam int NS   = 3;
    localparam int PT_W = 24;
    localparam int NST  = 1;

    // ---------------- clock / reset ----------------
    logic ap_clk = 1'b0;
    logic ap_rst = 1'b1;
    always #5 ap_clk = ~ap_clk;

    // main instance
    logic           in_valid, in_ready, in_a_sgn, in_b_sgn;
    logic [A_W-1:0] in_a;
    logic [B_W-1:0] in_b;
    logic           out_valid, out_ready;
    logic [P_W-1:0] out_p;
    logic [3:0]     occupancy;

    // truncating instance
    logic            t_in_valid, t_in_ready, t_in_a_sgn, t_in_b_sgn;
    logic [A_W-1:0]  t_in_a;
    logic [B_W-1:0]  t_in_b;
    logic            t_out_valid, t_out_ready;
    logic [PT_W-1:0] t_out_p;
    logic [3:0]      t_occupancy;

    exec_instr_gen_mul_pipe #(
        .A_W(A_W), .B_W(B_W), .P_W(P_W), .NUM_STAGE(NS)
    ) u_dut (
        .ap_clk    (ap_clk),
        .ap_rst    (ap_rst),
        .in_valid  (in_valid),
        .in_ready  (in_ready),
        .in_a      (in_a),
        .in_b      (in_b),
        .in_a_sgn  (in_a_sgn),
        .in_b_sgn  (in_b_sgn),
        .out_valid (out_valid),
        .out_ready (out_ready),
        .out_p     (out_p),
        .occupancy (occupancy)
    );

    exec_instr_gen_mul_pipe #(
        .A_W(A_W), .B_W(B_W), .P_W(PT_W), .NUM_STAGE(NST)
    ) u_dut_t (
        .ap_clk    (ap_clk),
        .ap_rst    (ap_rst),
        .in_valid  (t_in_valid),
        .in_ready  (t_in_ready),
        .in_a      (t_in_a),
        .in_b      (t_in_b),
        .in_a_sgn  (t_in_a_sgn),
        .in_b_sgn  (t_in_b_sgn),
        .out_valid (t_out_valid),
        .out_ready (t_out_ready),
        .out_p     (t_out_p),
        .occupancy (t_occupancy)
    );

    // ---------------- scoreboard ----------------
    logic [P_W-1:0] exp_q[$];
    int    n_chk = 0;
    int    n_bad = 0;
    int    n_out = 0;
    string cur_tag = "none";

    task automatic check(input string tag, input logic [63:0] got, input logic [63:0] exp);
        n_chk++;
        if (got !== exp) begin
            n_bad++;
            $display("FAIL %s got=%0h expected=%0h (t=%0t)", tag, got, exp, $time);
        end
    endtask

    // ---------------- driver tasks ----------------
    // Drive one cycle from a negedge; retire/accept decisions are made on the
    // values that will be present at the following posedge.
    task automatic cycle(input logic iv, input logic [15:0] a, input logic [15:0] b,
                         input logic as, input logic bs, input logic ordy,
                         input logic [31:0] exp, output logic fired);
        in_valid  = iv;
        in_a      = iv ? a : 16'($urandom);
        in_b      = iv ? b : 16'($urandom);
        in_a_sgn  = as;
        in_b_sgn  = bs;
        out_ready = ordy;
        #1;
        fired = in_valid && in_ready;
        if (out_valid && out_ready) begin
            n_out++;
            if (exp_q.size() == 0) check("spurious_out", 64'd1, 64'd0);
            else                   check(cur_tag, 64'(out_p), 64'(exp_q.pop_front()));
        end
        if (fired) exp_q.push_back(exp);
        @(negedge ap_clk);
    endtask

    task automatic idle();
        logic f;
        cycle(1'b0, 16'd0, 16'd0, 1'b0, 1'b0, 1'b1, 32'd0, f);
    endtask

    task automatic drain();
        int n;
        n = 0;
        while (exp_q.size() != 0 && n < 50) begin
            idle();
            n++;
        end
        check({cur_tag, "_drain"}, 64'(exp_q.size()), 64'd0);
    endtask

    // Cycles from accept until out_valid, counting the accept cycle's successor as 1.
    task automatic latency(input string tag, input int want);
        int lat;
        lat = 1;
        while (!out_valid && lat < 20) begin
            idle();
            lat++;
        end
        check(tag, 64'(lat), 64'(want));
    endtask

    // ---------------- stimulus ----------------
    initial begin
        logic f;
        int   j;
        int   guard;

        in_valid = 0; in_a = 0; in_b = 0; in_a_sgn = 0; in_b_sgn = 0; out_ready = 1;
        t_in_valid = 0; t_in_a = 0; t_in_b = 0; t_in_a_sgn = 0; t_in_b_sgn = 0; t_out_ready = 1;

        // reset state
        repeat (2) @(negedge ap_clk);
        check("rst_out_valid", 64'(out_valid), 64'd0);
        check("rst_out_p", 64'(out_p), 64'd0);
        check("rst_occ", 64'(occupancy), 64'd0);
        check("rst_t_out_p", 64'(t_out_p), 64'd0);
        ap_rst = 0;
        @(negedge ap_clk);
        #1;
        check("idle_in_ready", 64'(in_ready), 64'd1);
        @(negedge ap_clk);

        // unsigned max x max, with latency
        cur_tag = "unsigned";
        cycle(1'b1, 16'hFFFF, 16'hFFFF, 1'b0, 1'b0, 1'b1, 32'hFFFE0001, f);
        check("uns_fire", 64'(f), 64'd1);
        latency("uns_latency", NS);
        drain();

        // signed/unsigned mixes, back to back
        cur_tag = "signed";
        cycle(1'b1, 16'hFFFF, 16'h0002, 1'b1, 1'b1, 1'b1, 32'hFFFFFFFE, f);
        cycle(1'b1, 16'hFFFF, 16'h0002, 1'b1, 1'b0, 1'b1, 32'hFFFFFFFE, f);
        cycle(1'b1, 16'hFFFF, 16'h0002, 1'b0, 1'b1, 1'b1, 32'h0001FFFE, f);
        cycle(1'b1, 16'h8000, 16'h8000, 1'b1, 1'b1, 1'b1, 32'h40000000, f);
        drain();

        // streaming: 20 back-to-back beats
        cur_tag = "stream";
        n_out = 0;
        for (int i = 0; i < 20; i++) begin
            cycle(1'b1, 16'(i), 16'(i + 1), 1'b0, 1'b0, 1'b1, 32'(i * (i + 1)), f);
            check("stream_accept", 64'(f), 64'd1);
        end
        drain();
        check("stream_count", 64'(n_out), 64'd20);

        // backpressure: fill, stall 5 cycles, release
        cur_tag = "bp";
        n_out = 0;
        j = 0;
        for (int c = 0; c < NS; c++) begin
            cycle(1'b1, 16'(16'h100 + j), 16'd3, 1'b0, 1'b0, 1'b0, 32'((16'h100 + j) * 3), f);
            if (f) j++;
        end
        check("bp_filled", 64'(j), 64'(NS));
        for (int c = 0; c < 5; c++) begin
            cycle(1'b1, 16'(16'h100 + j), 16'd3, 1'b0, 1'b0, 1'b0, 32'((16'h100 + j) * 3), f);
            check("bp_no_accept", 64'(f), 64'd0);
            check("bp_in_ready", 64'(in_ready), 64'd0);
            check("bp_occ", 64'(occupancy), 64'(NS));
            check("bp_hold_valid", 64'(out_valid), 64'd1);
            check("bp_hold_p", 64'(out_p), 64'h300);
        end
        guard = 0;
        while (j < 6 && guard < 30) begin
            cycle(1'b1, 16'(16'h100 + j), 16'd3, 1'b0, 1'b0, 1'b1, 32'((16'h100 + j) * 3), f);
            if (f) j++;
            guard++;
        end
        drain();
        check("bp_count", 64'(n_out), 64'd6);

        // reset with two beats in flight
        cur_tag = "rst_mid";
        cycle(1'b1, 16'd5, 16'd6, 1'b0, 1'b0, 1'b1, 32'd30, f);
        cycle(1'b1, 16'd8, 16'd9, 1'b0, 1'b0, 1'b1, 32'd72, f);
        in_valid = 0;
        #1;
        check("pre_rst_occ", 64'(occupancy), 64'd2);
        ap_rst = 1;
        #1;
        check("mid_rst_out_valid", 64'(out_valid), 64'd0);
        check("mid_rst_occ", 64'(occupancy), 64'd0);
        exp_q.delete();
        @(negedge ap_clk);
        @(negedge ap_clk);
        ap_rst = 0;
        @(negedge ap_clk);
        cycle(1'b1, 16'd7, 16'd9, 1'b0, 1'b0, 1'b1, 32'd63, f);
        latency("post_rst_latency", NS);
        drain();

        // truncation on the 24-bit, single-stage instance
        t_in_a = 16'h1234; t_in_b = 16'h5678; t_in_a_sgn = 0; t_in_b_sgn = 0; t_in_valid = 1;
        #1;
        check("trunc_in_ready", 64'(t_in_ready), 64'd1);
        @(negedge ap_clk);
        t_in_a = 16'hFFFF; t_in_b = 16'h0002; t_in_a_sgn = 1; t_in_b_sgn = 1;
        check("trunc_valid", 64'(t_out_valid), 64'd1);
        check("trunc_uns", 64'(t_out_p), 64'h260060);
        @(negedge ap_clk);
        t_in_valid = 0;
        t_in_a = 16'($urandom);
        t_in_b = 16'($urandom);
        check("trunc_sgn", 64'(t_out_p), 64'hFFFFFE);
        @(negedge ap_clk);
        check("trunc_bubble_valid", 64'(t_out_valid), 64'd0);
        check("trunc_occ", 64'(t_occupancy), 64'd0);

        // final report
        $display("test done: total=%0d bad=%0d", n_chk, n_bad);
        $finish;
    end

    // Watchdog so the run always ends.
    initial begin
        #200000;
        $display("FAIL watchdog got=timeout expected=finish");
        $fatal(1, "watchdog expired");
    end

endmodule
